// File: rtl/clock_counter_reader.sv
// SPI master/sequencer: reads the PPS-captured clock count, validates it and derives delta/freq error.
// Optional PPS watchdog (pps_lost_o) enabled by defining CLOCK_COUNTER_READER_PPS_TIMEOUT_EN.
module clock_counter_reader #(
  parameter int unsigned    COUNTER_BITS   = 27,
  parameter int unsigned    SPI_DIV        = 4,
  parameter int unsigned    SETTLE_CYCLES  = 16,
`ifdef CLOCK_COUNTER_READER_PPS_TIMEOUT_EN
  parameter int unsigned    TIMEOUT_CYCLES = 33554432,
`endif
  parameter longint unsigned EXPECTED_COUNT = 52000000
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    pps_in_i,
  input  logic                    enable_i,
  output logic                    spi_clk_o,
  output logic                    spi_sen_o,
  input  logic                    spi_in_i,
  output logic                    busy_o,
  output logic [COUNTER_BITS-1:0] sample_o,
  output logic                    sample_valid_o,
  output logic [COUNTER_BITS-1:0] delta_o,
  output logic [COUNTER_BITS:0]   freq_err_o,
  output logic                    delta_valid_o,
  output logic                    no_data_o,
  output logic                    stale_o,
`ifdef CLOCK_COUNTER_READER_PPS_TIMEOUT_EN
  output logic                    pps_lost_o,
`endif
  output logic                    overrun_o
);

  typedef enum logic [2:0] {
    StIdle, StSettle, StLoadLo, StLoadHi, StShiftLo, StShiftHi, StCalc
  } state_e;

  localparam int unsigned TimerMax = (SETTLE_CYCLES > SPI_DIV) ? SETTLE_CYCLES : SPI_DIV;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam int unsigned IdxW     = $clog2(COUNTER_BITS + 1);
  localparam logic [TimerW-1:0]       SettleLast = TimerW'(SETTLE_CYCLES - 1);
  localparam logic [TimerW-1:0]       DivLast    = TimerW'(SPI_DIV - 1);
  localparam logic [COUNTER_BITS-1:0] ExpCount   = COUNTER_BITS'(EXPECTED_COUNT);

  state_e                  state_q, state_d;
  logic [TimerW-1:0]       timer_q, timer_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [COUNTER_BITS:0]   rx_q, rx_d;
  logic                    pps_s1_q, pps_s2_q, pps_s3_q;
  logic                    pps_edge, pps_start;
  logic                    have_prev_q, have_prev_d;
  logic [COUNTER_BITS-1:0] sample_q, sample_d, delta_q, delta_d;
  logic [COUNTER_BITS:0]   ferr_q, ferr_d;
  logic                    sv_q, sv_d, dv_q, dv_d, nd_q, nd_d, st_q, st_d, ov_q, ov_d;
  logic                    spi_clk_q, spi_clk_d, spi_sen_q, spi_sen_d;
  logic                    rx_flag;
  logic [COUNTER_BITS-1:0] rx_data, delta_new;
  logic [COUNTER_BITS:0]   ferr_new;
  logic                    wd_fire;

  assign pps_edge  = pps_s2_q & ~pps_s3_q;
  assign pps_start = pps_edge & enable_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pps_s1_q <= 1'b0;
      pps_s2_q <= 1'b0;
      pps_s3_q <= 1'b0;
    end else begin
      pps_s1_q <= pps_in_i;
      pps_s2_q <= pps_s1_q;
      pps_s3_q <= pps_s2_q;
    end
  end

  // Sequencer: every phase timer restarts at zero on a state change.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    idx_d   = idx_q;
    rx_d    = rx_q;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (pps_start) state_d = StSettle;
      end
      StSettle: begin
        if (timer_q == SettleLast) begin
          state_d = StLoadLo;
          timer_d = '0;
        end
      end
      StLoadLo: begin
        if (timer_q == DivLast) begin
          state_d = StLoadHi;
          timer_d = '0;
        end
      end
      StLoadHi: begin
        if (timer_q == DivLast) begin
          state_d = StShiftLo;
          timer_d = '0;
          idx_d   = IdxW'(COUNTER_BITS);
        end
      end
      StShiftLo: begin
        if (timer_q == DivLast) begin
          timer_d = '0;
          rx_d    = {rx_q[COUNTER_BITS-1:0], spi_in_i};
          state_d = (idx_q == '0) ? StCalc : StShiftHi;
        end
      end
      StShiftHi: begin
        if (timer_q == DivLast) begin
          timer_d = '0;
          idx_d   = idx_q - 1'b1;
          state_d = StShiftLo;
        end
      end
      StCalc: begin
        timer_d = '0;
        state_d = StIdle;
      end
      default: begin
        timer_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign spi_clk_d = (state_d == StLoadHi) || (state_d == StShiftHi);
  assign spi_sen_d = !((state_d == StLoadLo) || (state_d == StLoadHi));

  assign rx_flag   = rx_q[COUNTER_BITS];
  assign rx_data   = rx_q[COUNTER_BITS-1:0];
  assign delta_new = rx_data - sample_q;
  // Both operands are magnitudes, so the extra bit holds the full signed range.
  assign ferr_new  = {1'b0, delta_new} - {1'b0, ExpCount};

`ifdef CLOCK_COUNTER_READER_PPS_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           wd_held_q, wd_held_d, pps_lost_q;

  always_comb begin
    wd_d      = wd_q;
    wd_held_d = wd_held_q;
    wd_fire   = 1'b0;
    if (pps_edge) begin
      wd_d      = '0;
      wd_held_d = 1'b0;
    end else if (enable_i && !wd_held_q) begin
      if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
        wd_fire   = 1'b1;
        wd_held_d = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wd_q       <= '0;
      wd_held_q  <= 1'b0;
      pps_lost_q <= 1'b0;
    end else begin
      wd_q       <= wd_d;
      wd_held_q  <= wd_held_d;
      pps_lost_q <= wd_fire;
    end
  end

  assign pps_lost_o = pps_lost_q;
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    sample_d    = sample_q;
    delta_d     = delta_q;
    ferr_d      = ferr_q;
    have_prev_d = have_prev_q;
    sv_d        = 1'b0;
    dv_d        = 1'b0;
    nd_d        = 1'b0;
    st_d        = 1'b0;
    if (state_q == StCalc) begin
      if (!rx_flag) begin
        nd_d = 1'b1;
      end else if (have_prev_q && (rx_data == sample_q)) begin
        st_d = 1'b1;
      end else begin
        sample_d    = rx_data;
        sv_d        = 1'b1;
        have_prev_d = 1'b1;
        if (have_prev_q) begin
          delta_d = delta_new;
          ferr_d  = ferr_new;
          dv_d    = 1'b1;
        end
      end
    end
    if (wd_fire) have_prev_d = 1'b0;
  end

  assign ov_d = pps_start && (state_q != StIdle);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      idx_q       <= '0;
      rx_q        <= '0;
      have_prev_q <= 1'b0;
      sample_q    <= '0;
      delta_q     <= '0;
      ferr_q      <= '0;
      sv_q        <= 1'b0;
      dv_q        <= 1'b0;
      nd_q        <= 1'b0;
      st_q        <= 1'b0;
      ov_q        <= 1'b0;
      spi_clk_q   <= 1'b0;
      spi_sen_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      rx_q        <= rx_d;
      have_prev_q <= have_prev_d;
      sample_q    <= sample_d;
      delta_q     <= delta_d;
      ferr_q      <= ferr_d;
      sv_q        <= sv_d;
      dv_q        <= dv_d;
      nd_q        <= nd_d;
      st_q        <= st_d;
      ov_q        <= ov_d;
      spi_clk_q   <= spi_clk_d;
      spi_sen_q   <= spi_sen_d;
    end
  end

  assign spi_clk_o      = spi_clk_q;
  assign spi_sen_o      = spi_sen_q;
  assign busy_o         = (state_q != StIdle);
  assign sample_o       = sample_q;
  assign sample_valid_o = sv_q;
  assign delta_o        = delta_q;
  assign freq_err_o     = ferr_q;
  assign delta_valid_o  = dv_q;
  assign no_data_o      = nd_q;
  assign stale_o        = st_q;
  assign overrun_o      = ov_q;

endmodule

// File: tb/tb_clock_counter_reader.sv
// Directed bench for clock_counter_reader with a behavioural model of the counter's shift register.
module tb_clock_counter_reader;
  localparam int unsigned CB = 27;
  // busy rising (first settle cycle) to the registered result pulse
  localparam int LAT = 4 + 2 * 2 + (2 * (CB + 1) - 1) * 2 + 1;

  typedef struct packed {
    logic          flag;
    logic [CB-1:0] count;
    logic          exp_sv;
    logic          exp_dv;
    logic          exp_nd;
    logic          exp_st;
    logic [CB-1:0] exp_sample;
    logic [CB-1:0] exp_delta;
    logic [CB:0]   exp_ferr;
  } vec_t;

  logic clk = 1'b0;
  logic reset, pps, enable, spi_in, spi_clk, spi_sen, busy;
  logic sample_valid, delta_valid, no_data, stale, overrun;
  logic [CB-1:0] sample, delta;
  logic [CB:0]   freq_err;
`ifdef CLOCK_COUNTER_READER_PPS_TIMEOUT_EN
  logic pps_lost;
  int   n_lost = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_sv, n_dv, n_nd, n_st, n_ov, lat;
  logic [CB:0] cap_word = '0;
  logic [CB:0] sr = '0;
  logic        spi_clk_prev = 1'b0;
  vec_t        vecs [6];

  always #5 clk = ~clk;

  clock_counter_reader #(
    .COUNTER_BITS  (CB),
    .SPI_DIV       (2),
    .SETTLE_CYCLES (4),
`ifdef CLOCK_COUNTER_READER_PPS_TIMEOUT_EN
    .TIMEOUT_CYCLES(500),
`endif
    .EXPECTED_COUNT(1000)
  ) u_dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .pps_in_i      (pps),
    .enable_i      (enable),
    .spi_clk_o     (spi_clk),
    .spi_sen_o     (spi_sen),
    .spi_in_i      (spi_in),
    .busy_o        (busy),
    .sample_o      (sample),
    .sample_valid_o(sample_valid),
    .delta_o       (delta),
    .freq_err_o    (freq_err),
    .delta_valid_o (delta_valid),
    .no_data_o     (no_data),
    .stale_o       (stale),
`ifdef CLOCK_COUNTER_READER_PPS_TIMEOUT_EN
    .pps_lost_o    (pps_lost),
`endif
    .overrun_o     (overrun)
  );

  // Counter model: load on spi_clk rise with sen=0, shift on rise with sen=1, MSB out.
  always @(negedge clk) begin : counter_model
    logic [CB:0] nxt;
    nxt = sr;
    if (spi_clk && !spi_clk_prev) nxt = spi_sen ? {sr[CB-1:0], 1'b0} : cap_word;
    sr           <= nxt;
    spi_in       <= nxt[CB];
    spi_clk_prev <= spi_clk;
  end

`ifdef CLOCK_COUNTER_READER_PPS_TIMEOUT_EN
  always @(negedge clk) if (pps_lost) n_lost++;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse PPS, follow one complete read, count result pulses; optional second PPS during shift.
  task automatic run_read(input logic [CB:0] word, input int ov_delay);
    int t, b_cyc, end_t, shift_t, ov_t;
    bit seen_busy, saw_load;
    n_sv = 0; n_dv = 0; n_nd = 0; n_st = 0; n_ov = 0; lat = -1;
    b_cyc = -1; end_t = -1; shift_t = -1; ov_t = -1;
    seen_busy = 1'b0; saw_load = 1'b0;
    cap_word = word;
    pps = 1'b1;
    t = 0;
    while ((end_t < 0 || t < end_t) && t < 600) begin
      @(negedge clk);
      t++;
      if (t == 4 || (ov_t >= 0 && t == ov_t + 4)) pps = 1'b0;
      if (busy && !seen_busy) begin
        seen_busy = 1'b1;
        b_cyc = t;
      end
      if (!spi_sen) saw_load = 1'b1;
      if (saw_load && spi_sen && shift_t < 0) shift_t = t;
      if (ov_delay >= 0 && shift_t >= 0 && ov_t < 0 && t == shift_t + ov_delay) begin
        pps = 1'b1;
        ov_t = t;
      end
      if (sample_valid || no_data || stale) lat = t - b_cyc;
      if (sample_valid) n_sv++;
      if (delta_valid) n_dv++;
      if (no_data) n_nd++;
      if (stale) n_st++;
      if (overrun) n_ov++;
      if (seen_busy && !busy && end_t < 0) end_t = t + 3;
    end
    pps = 1'b0;
    check("read_done", 64'(end_t >= 0 && t == end_t), 64'd1);
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    run_read({v.flag, v.count}, -1);
    check($sformatf("v%0d_sample_valid", i), 64'(n_sv), 64'(v.exp_sv));
    check($sformatf("v%0d_delta_valid", i), 64'(n_dv), 64'(v.exp_dv));
    check($sformatf("v%0d_no_data", i), 64'(n_nd), 64'(v.exp_nd));
    check($sformatf("v%0d_stale", i), 64'(n_st), 64'(v.exp_st));
    check($sformatf("v%0d_overrun", i), 64'(n_ov), 64'd0);
    check($sformatf("v%0d_latency", i), 64'(lat), 64'(LAT));
    check($sformatf("v%0d_sample", i), 64'(sample), 64'(v.exp_sample));
    check($sformatf("v%0d_delta", i), 64'(delta), 64'(v.exp_delta));
    check($sformatf("v%0d_freq_err", i), 64'(freq_err), 64'(v.exp_ferr));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int t;
    bit found;
    vecs[0] = '{1'b1, 27'd5000, 1'b1, 1'b0, 1'b0, 1'b0, 27'd5000, 27'd0, 28'd0};
    vecs[1] = '{1'b1, 27'd6010, 1'b1, 1'b1, 1'b0, 1'b0, 27'd6010, 27'd1010, 28'd10};
    vecs[2] = '{1'b1, 27'h7FFFF00, 1'b1, 1'b0, 1'b0, 1'b0, 27'h7FFFF00, 27'd0, 28'd0};
    vecs[3] = '{1'b1, 27'h00002E0, 1'b1, 1'b1, 1'b0, 1'b0, 27'h2E0, 27'h3E0, 28'hFFFFFF8};
    vecs[4] = '{1'b0, 27'h1234567, 1'b0, 1'b0, 1'b1, 1'b0, 27'h2E0, 27'h3E0, 28'hFFFFFF8};
    vecs[5] = '{1'b1, 27'h00002E0, 1'b0, 1'b0, 1'b0, 1'b1, 27'h2E0, 27'h3E0, 28'hFFFFFF8};

    reset = 1'b1; pps = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_spi_clk", 64'(spi_clk), 64'd0);
    check("rst_spi_sen", 64'(spi_sen), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sample", 64'(sample), 64'd0);
    check("rst_pulses", 64'({sample_valid, delta_valid, no_data, stale, overrun}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    apply_vec(0);
    apply_vec(1);

    // Abort a read in SHIFT_HI; have_prev must be cleared by the reset.
    cap_word = {1'b1, 27'd777};
    pps = 1'b1;
    found = 1'b0;
    t = 0;
    while (!found && t < 400) begin
      @(negedge clk);
      t++;
      if (t == 4) pps = 1'b0;
      if (spi_clk && spi_sen) found = 1'b1;
    end
    pps = 1'b0;
    check("reach_shift_hi", 64'(found), 64'd1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_spi_clk", 64'(spi_clk), 64'd0);
    check("mid_rst_spi_sen", 64'(spi_sen), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_sample", 64'(sample), 64'd0);
    check("mid_rst_pulses", 64'({sample_valid, delta_valid, no_data, stale, overrun}), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 2; i < 6; i++) apply_vec(i);

    // Second PPS edge lands during the shift phase.
    run_read({1'b1, 27'h0100000}, 10);
    check("ovr_overrun", 64'(n_ov), 64'd1);
    check("ovr_sample_valid", 64'(n_sv), 64'd1);
    check("ovr_delta_valid", 64'(n_dv), 64'd1);
    check("ovr_sample", 64'(sample), 64'h0100000);
    check("ovr_delta", 64'(delta), 64'hFFD20);
    check("ovr_freq_err", 64'(freq_err), 64'd1046840);

    // PPS ignored while disabled; previous sample is retained for the next delta.
    enable = 1'b0;
    pps = 1'b1;
    t = 0;
    found = 1'b0;
    repeat (40) begin
      @(negedge clk);
      t++;
      if (t == 4) pps = 1'b0;
      if (busy || overrun) found = 1'b1;
    end
    check("dis_no_activity", 64'(found), 64'd0);
    enable = 1'b1;
    @(negedge clk);
    run_read({1'b1, 27'h0200000}, -1);
    check("en_sample_valid", 64'(n_sv), 64'd1);
    check("en_delta_valid", 64'(n_dv), 64'd1);
    check("en_delta", 64'(delta), 64'h100000);
    check("en_freq_err", 64'(freq_err), 64'd1047576);

`ifdef CLOCK_COUNTER_READER_PPS_TIMEOUT_EN
    check("lost_none_yet", 64'(n_lost), 64'd0);
    repeat (700) @(negedge clk);
    check("lost_single", 64'(n_lost), 64'd1);
    run_read({1'b1, 27'h0300000}, -1);
    check("lost_sample_valid", 64'(n_sv), 64'd1);
    check("lost_delta_valid", 64'(n_dv), 64'd0);
    check("lost_sample", 64'(sample), 64'h0300000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/clock_counter_reader.md
Name: clock_counter_reader

Overview:
- SPI master and sequencer that reads the 1PPS-captured high-clock count from the clock counter block once per second.
- Checks the valid flag in each capture and detects stale captures.
- Computes the count delta between consecutive captures (modulo 2^COUNTER_BITS) and the signed frequency error against the nominal count.
- Sits between the counter's SPI readout port and the MCU/discipline logic. Owns spi_clk/spi_sen generation for that port.

Parameters:
- COUNTER_BITS, 27, capture width excluding flag; serial word is COUNTER_BITS+1 bits, MSB (flag) first.
- SPI_DIV, 4, clk cycles per spi_clk half-period (>=1).
- SETTLE_CYCLES, 16, clk cycles from synchronized PPS rising edge to start of readout (>=1).
- EXPECTED_COUNT, 52000000, nominal high-clock count per second, taken modulo 2^COUNTER_BITS.
- TIMEOUT_CYCLES, 33554432, PPS watchdog limit (optional feature only).

Ports:
- clk  in  1  system clock; all logic, including the generated spi_clk, is in this domain.
- reset  in  1  asynchronous, active-high reset.
- pps_in  in  1  raw 1PPS, asynchronous; 2-FF synchronized internally.
- enable  in  1  0 = ignore PPS edges; an in-progress read completes.
- spi_clk  out  1  serial clock to counter.
- spi_sen  out  1  serial enable to counter; 0 = load, 1 = shift.
- spi_in  in  1  serial data from counter (counter's spi_out).
- busy  out  1  readout/calc in progress.
- sample  out  COUNTER_BITS  last captured count.
- sample_valid  out  1  1-cycle pulse: new sample accepted.
- delta  out  COUNTER_BITS  (sample - prev_sample) mod 2^COUNTER_BITS.
- freq_err  out  COUNTER_BITS+1  signed, delta - EXPECTED_COUNT.
- delta_valid  out  1  1-cycle pulse: delta/freq_err updated.
- no_data  out  1  1-cycle pulse: flag bit read as 0.
- stale  out  1  1-cycle pulse: capture equals previous sample.
- overrun  out  1  1-cycle pulse: PPS edge while busy.

Behaviour:
- Reset values: spi_clk=0, spi_sen=1, busy=0, sample=0, delta=0, freq_err=0, all pulses 0.
- Reset also returns the FSM to IDLE, clears have_prev, and clears the PPS synchronizer.
- Reset mid-transfer aborts immediately; the partial word is discarded.
- PPS edge: rising edge detected on the synchronized signal. Counts only when enable=1.
- FSM states:
  - IDLE: on PPS edge with enable=1 -> SETTLE; busy=1 from the next cycle.
  - SETTLE: wait SETTLE_CYCLES -> LOAD_LO.
  - LOAD_LO: spi_sen=0, spi_clk=0 for SPI_DIV cycles -> LOAD_HI.
  - LOAD_HI: spi_sen=0, spi_clk=1 for SPI_DIV cycles; the counter loads on this rising edge -> SHIFT_LO, bit index=COUNTER_BITS.
  - SHIFT_LO: spi_sen=1, spi_clk=0 for SPI_DIV cycles. Shift spi_in into the receive register on the last cycle.
    - If index==0 -> CALC.
    - Otherwise -> SHIFT_HI.
  - SHIFT_HI: spi_clk=1 for SPI_DIV cycles; the counter shifts on this edge; index-1 -> SHIFT_LO.
  - CALC: one cycle, evaluated in the priority order below; then -> IDLE with busy=0.
    - flag==0: no_data pulse; sample unchanged.
    - Else if have_prev and data==sample: stale pulse; sample unchanged.
    - Else: sample<=data, sample_valid pulse. If have_prev, delta and freq_err update and delta_valid pulses. have_prev<=1.
- Output timing: all CALC outputs are registered and become visible the cycle after CALC. Pulses are exactly 1 cycle.
- Transfer latency:
  - PPS sync edge to CALC = SETTLE_CYCLES + 2*SPI_DIV + (2*(COUNTER_BITS+1)-1)*SPI_DIV cycles.
  - Exactly COUNTER_BITS+1 samples are taken and COUNTER_BITS shifting rising edges are issued.
- Arithmetic:
  - delta wraps naturally. Example: prev=0x7FFFFF0, new=0x0000010 -> delta=0x20.
  - freq_err is sign-extended subtraction, COUNTER_BITS+1 bits, no saturation.
- Simultaneous events:
  - PPS edge in any non-IDLE state: ignored, overrun pulse.
  - PPS edge in the CALC cycle: also overrun.
- enable drop: enable=0 in IDLE blocks new reads; have_prev is kept.

Optional Feature:
- Macro: CLOCK_COUNTER_READER_PPS_TIMEOUT_EN.
- With the macro: a watchdog counts clk cycles since the last synchronized PPS edge, and only while enable=1.
  - On reaching TIMEOUT_CYCLES, it pulses an extra output pps_lost (1 bit, reset 0) for 1 cycle.
  - It also clears have_prev, so the next good sample yields no delta.
  - It then holds until the next edge; no repeated pulses.
- Without the macro: no watchdog logic, no pps_lost port; have_prev is cleared only by reset.

Test Plan (COUNTER_BITS=27, SPI_DIV=2, SETTLE_CYCLES=4, EXPECTED_COUNT=1000; bench models the counter's shift register):
- Reset mid-transfer in SHIFT_HI: assert reset -> next cycle spi_clk=0, spi_sen=1, busy=0, no pulses. A following PPS performs a full read with no delta_valid.
- Two PPS captures, counts 5000 then 6010 (flag=1):
  - First read: sample_valid only.
  - Second read: delta=1010, freq_err=+10, delta_valid.
  - Check the latency formula cycle-exactly.
- Captures 0x7FFFF00 then 0x00002E0: delta=0x3E0 (992), freq_err=-8.
- Flag bit 0 -> no_data pulse, sample unchanged. Repeated identical capture -> stale pulse, no delta_valid.
- PPS edge 10 cycles into SHIFT_LO -> overrun pulse; the read completes normally; exactly one sample_valid.
- With CLOCK_COUNTER_READER_PPS_TIMEOUT_EN, TIMEOUT_CYCLES=500: no PPS for 500 cycles -> single pps_lost pulse. The next capture gives sample_valid without delta_valid.
